text_buffer_writer: RTL and testbench
=====================================

TEXT_BUFFER_WRITER -- requirements
Module: text_buffer_writer

Interface
REQ-001 Parameter COLS, default 13, characters per text row (104-pixel rectangle / 8-pixel glyph).
REQ-002 Parameter ROWS, default 16, text rows (256-pixel rectangle / 16-line glyph).
REQ-003 Parameter CHANNELS, default 13, number of voltage channels, one per row starting at row 0.
REQ-004 pclk  in  1  pixel clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  measurement offered.
REQ-007 in_ready  out  1  block can accept a measurement.
REQ-008 in_channel  in  4  channel index of offered measurement.
REQ-009 in_mv  in  12  measured voltage in millivolts, unsigned, 0..4095.
REQ-010 update_done  out  1  one-cycle pulse when a row rewrite completes.
REQ-011 chan_err  out  1  one-cycle pulse when an accepted channel index is >= CHANNELS.
REQ-012 text_xy  in  8  display read address, row*COLS+col, from the character-drawing stage.
REQ-013 char_code  out  7  ASCII code at text_xy, registered.

Function
REQ-014 Storage: COLS*ROWS (208) x 7-bit character memory; address = row*COLS + col.
REQ-015 Read port: char_code = mem[text_xy] one pclk after text_xy is presented; every cycle, independent of FSM state.
REQ-016 text_xy >= 208 -> char_code = 0x20 (space).
REQ-017 Same-cycle read and write to one address -> char_code returns the old contents.
REQ-018 Row r < CHANNELS layout, cols 0..12: 'C','H',tens(r),units(r),':',d3,d2,d1,d0,'m','V',' ',' ' (d3 = thousands digit, leading zeros kept, digits as ASCII 0x30+n).
REQ-019 Rows CHANNELS..ROWS-1: all spaces.
REQ-020 FSM states: CLEAR, IDLE, CONV, WRITE.
REQ-021 CLEAR: entered on reset; writes one address per cycle, 0 to 207 ascending; rows < CHANNELS get the REQ-018 layout with value 0000, other rows spaces; after address 207 -> IDLE.
REQ-022 in_ready = 1 only in IDLE.
REQ-023 Accept = in_valid && in_ready on a rising edge; capture in_channel and in_mv; IDLE -> CONV.
REQ-024 Accepted in_channel >= CHANNELS: chan_err pulses the next cycle, FSM stays in IDLE, no memory write, no update_done.
REQ-025 CONV: sequential binary-to-BCD (shift-add-3), 12 iterations, one per cycle, 16-bit BCD result; then -> WRITE.
REQ-026 WRITE: writes columns 0..12 of row in_channel, one per cycle, 13 cycles; then -> IDLE with a one-cycle update_done pulse in that same first IDLE cycle.
REQ-027 Accept to update_done = 26 cycles; in_ready low for 25 cycles after the accept edge, high again with update_done.
REQ-028 in_valid while not ready: no effect; the offer stays pending for the master (it must hold its data).
REQ-029 Back-to-back offers: the next accept is possible in the update_done cycle.
REQ-030 Write address arithmetic is 8-bit; row*13+col never exceeds 207; no wrap.

Reset
REQ-031 rst high on any edge: state -> CLEAR, CLEAR address -> 0, in_ready = 0, update_done = 0, chan_err = 0, char_code = 0x20, captured channel/value -> 0.
REQ-032 rst mid-CONV or mid-WRITE aborts the update (no update_done); CLEAR then rewrites all 208 entries.
REQ-033 in_ready first goes high on the cycle after CLEAR writes address 207, i.e. 208 cycles after rst deasserts.

Verification
REQ-034 Reset, then read addresses 0..207 -> row 0 reads "CH00:0000mV  ", row 12 reads "CH12:0000mV  ", rows 13..15 all 0x20; in_ready rises exactly 208 cycles after rst falls.
REQ-035 Accept ch=5, mv=3307 -> update_done 26 cycles later; addresses 65..77 read "CH05:3307mV  "; other rows unchanged.
REQ-036 Accept ch=12, mv=4095, then ch=0, mv=7 in the update_done cycle -> row 12 = "CH12:4095mV  ", row 0 = "CH00:0007mV  ", two update_done pulses 26 cycles apart.
REQ-037 Accept ch=13, mv=100 -> chan_err pulse next cycle, in_ready stays high, no update_done, memory unchanged.
REQ-038 rst asserted 10 cycles into WRITE for ch=3 -> no update_done; after CLEAR, row 3 = "CH03:0000mV  ".
REQ-039 text_xy=200 and text_xy=230 in successive cycles -> char_code = 0x20 then 0x20 with 1-cycle latency; text_xy=0 -> 'C' (0x43) next cycle.

Source files
------------

// File: rtl/text_buffer_writer.sv
// ---------------------------------------------------------------------------
// text_buffer_writer
//
// Character buffer for a voltage read-out panel. Each accepted measurement
// (channel, millivolts) is turned into decimal digits and written into a
// COLS x ROWS text memory as the row "CHnn:ddddmV  ". The character-drawing
// stage reads the memory through a registered read port that runs every
// cycle, independent of the writer.
//
// After reset the whole memory is initialised one address per cycle:
// channel rows get "CHnn:0000mV  " and the spare rows are filled with spaces.
//
// Ports
//   pclk         pixel clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   in_valid     measurement offered
//   in_ready     block can accept a measurement (high only when idle)
//   in_channel   channel index of the offered measurement
//   in_mv        measured voltage in millivolts, unsigned
//   update_done  one-cycle pulse when a row rewrite completes
//   chan_err     one-cycle pulse when an accepted channel is out of range
//   text_xy      display read address, row*COLS+col
//   char_code    ASCII code at text_xy, one cycle later
// ---------------------------------------------------------------------------
module text_buffer_writer #(
    parameter int COLS     = 13,
    parameter int ROWS     = 16,
    parameter int CHANNELS = 13
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_channel,
    input  logic [11:0] in_mv,
    output logic        update_done,
    output logic        chan_err,
    input  logic [7:0]  text_xy,
    output logic [6:0]  char_code
);

    localparam int         DEPTH    = COLS * ROWS;
    localparam logic [8:0] DEPTH_L  = 9'(DEPTH);
    localparam logic [7:0] COLS_L   = 8'(COLS);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [4:0] CHAN_L   = 5'(CHANNELS);
    localparam logic [3:0] LAST_BIT = 4'd11;
    localparam logic [6:0] SPACE    = 7'h20;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        CONV,
        WRITE
    } state_t;

    state_t      state_reg;
    logic [3:0]  row_reg;
    logic [3:0]  col_reg;
    logic [3:0]  bit_cnt_reg;
    logic [11:0] bin_reg;
    logic [15:0] bcd_reg;
    logic        in_ready_reg;
    logic        update_done_reg;
    logic        chan_err_reg;
    logic [6:0]  char_code_reg;

    logic [6:0]  mem [0:DEPTH-1];

    // Write-port signals, derived from the row/col walk of CLEAR and WRITE.
    logic [15:0] bcd_adj;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        row_is_chan;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [6:0]  wr_data;

    function automatic logic [6:0] ascii_digit(input logic [3:0] d);
        return 7'h30 + {3'b000, d};
    endfunction

    // Shift-add-3: every BCD digit of 5 or more is bumped by 3 before the
    // next left shift, so that the shift carries correctly into the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Character generator for the cell currently addressed by row_reg/col_reg.
    // During CLEAR bcd_reg is held at zero, so channel rows come out as 0000.
    always_comb begin
        tens        = (row_reg >= 4'd10) ? 4'd1 : 4'd0;
        units       = (row_reg >= 4'd10) ? row_reg - 4'd10 : row_reg;
        row_is_chan = ({1'b0, row_reg} < CHAN_L);
        wr_en       = !rst && ((state_reg == CLEAR) || (state_reg == WRITE));
        // row <= 15 and col <= 12 keep this inside 0..207 with 8-bit math.
        wr_addr     = ({4'b0000, row_reg} * COLS_L) + {4'b0000, col_reg};
        wr_data     = SPACE;
        if (row_is_chan) begin
            case (col_reg)
                4'd0:    wr_data = 7'h43;                    // 'C'
                4'd1:    wr_data = 7'h48;                    // 'H'
                4'd2:    wr_data = ascii_digit(tens);
                4'd3:    wr_data = ascii_digit(units);
                4'd4:    wr_data = 7'h3A;                    // ':'
                4'd5:    wr_data = ascii_digit(bcd_reg[15:12]);
                4'd6:    wr_data = ascii_digit(bcd_reg[11:8]);
                4'd7:    wr_data = ascii_digit(bcd_reg[7:4]);
                4'd8:    wr_data = ascii_digit(bcd_reg[3:0]);
                4'd9:    wr_data = 7'h6D;                    // 'm'
                4'd10:   wr_data = 7'h56;                    // 'V'
                default: wr_data = SPACE;
            endcase
        end
    end

    // Control FSM. row_reg/col_reg double as the CLEAR sweep position and as
    // the captured channel plus write column during an update.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg       <= CLEAR;
            row_reg         <= 4'd0;
            col_reg         <= 4'd0;
            bit_cnt_reg     <= 4'd0;
            bin_reg         <= 12'd0;
            bcd_reg         <= 16'd0;
            in_ready_reg    <= 1'b0;
            update_done_reg <= 1'b0;
            chan_err_reg    <= 1'b0;
        end else begin
            update_done_reg <= 1'b0;
            chan_err_reg    <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    if (col_reg == LAST_COL) begin
                        col_reg <= 4'd0;
                        if (row_reg == LAST_ROW) begin
                            row_reg      <= 4'd0;
                            state_reg    <= IDLE;
                            in_ready_reg <= 1'b1;
                        end else begin
                            row_reg <= row_reg + 4'd1;
                        end
                    end else begin
                        col_reg <= col_reg + 4'd1;
                    end
                end

                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        if ({1'b0, in_channel} >= CHAN_L) begin
                            // Out-of-range channel: flag it and stay ready.
                            chan_err_reg <= 1'b1;
                        end else begin
                            row_reg      <= in_channel;
                            col_reg      <= 4'd0;
                            bin_reg      <= in_mv;
                            bcd_reg      <= 16'd0;
                            bit_cnt_reg  <= 4'd0;
                            in_ready_reg <= 1'b0;
                            state_reg    <= CONV;
                        end
                    end
                end

                CONV: begin
                    bcd_reg <= {bcd_adj[14:0], bin_reg[11]};
                    bin_reg <= {bin_reg[10:0], 1'b0};
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_reg <= WRITE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end

                WRITE: begin
                    if (col_reg == LAST_COL) begin
                        col_reg         <= 4'd0;
                        state_reg       <= IDLE;
                        in_ready_reg    <= 1'b1;
                        update_done_reg <= 1'b1;
                    end else begin
                        col_reg <= col_reg + 4'd1;
                    end
                end

                default: state_reg <= CLEAR;
            endcase
        end
    end

    // Character memory write port.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-cycle write to the same address returns the
    // previous contents. Addresses beyond the buffer read as a space.
    always_ff @(posedge pclk) begin
        if (rst) begin
            char_code_reg <= SPACE;
        end else if ({1'b0, text_xy} >= DEPTH_L) begin
            char_code_reg <= SPACE;
        end else begin
            char_code_reg <= mem[text_xy];
        end
    end

    assign in_ready    = in_ready_reg;
    assign update_done = update_done_reg;
    assign chan_err    = chan_err_reg;
    assign char_code   = char_code_reg;

endmodule

// File: tb/tb_text_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_text_buffer_writer
//
// Self-checking bench for text_buffer_writer. Keeps a reference image of the
// character memory built from formatted strings ("CH%02d:%04dmV  "), drives
// directed and random measurements, and compares timing and memory contents.
// Outputs are sampled on the falling edge of pclk.
// ---------------------------------------------------------------------------
module tb_text_buffer_writer;

    localparam int COLS     = 13;
    localparam int ROWS     = 16;
    localparam int CHANNELS = 13;
    localparam int DEPTH    = COLS * ROWS;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_channel = 4'd0;
    logic [11:0] in_mv = 12'd0;
    logic [7:0]  text_xy = 8'd0;
    logic        in_ready;
    logic        update_done;
    logic        chan_err;
    logic [6:0]  char_code;

    int     errors = 0;
    int     checks = 0;
    longint cycle = 0;
    longint last_done_cycle = -1;
    byte    model [DEPTH];

    text_buffer_writer #(
        .COLS(COLS),
        .ROWS(ROWS),
        .CHANNELS(CHANNELS)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_channel(in_channel),
        .in_mv(in_mv),
        .update_done(update_done),
        .chan_err(chan_err),
        .text_xy(text_xy),
        .char_code(char_code)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Expected text of one cell, straight from the row format.
    function automatic byte exp_char(input int r, input int c, input int mv);
        string s;
        if (r >= CHANNELS) return 8'h20;
        s = $sformatf("CH%02d:%04dmV  ", r, mv);
        return s[c];
    endfunction

    task automatic model_set_row(input int r, input int mv);
        for (int c = 0; c < COLS; c++) model[r*COLS + c] = exp_char(r, c, mv);
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) model_set_row(r, 0);
    endtask

    // Called on a falling edge; presents an address and checks it one cycle later.
    task automatic read_check(input int addr);
        text_xy = 8'(addr);
        @(negedge pclk);
        check_eq($sformatf("mem[%0d]", addr), int'(char_code), int'(model[addr]));
    endtask

    task automatic check_row(input int r);
        for (int c = 0; c < COLS; c++) read_check(r*COLS + c);
    endtask

    task automatic check_all();
        for (int a = 0; a < DEPTH; a++) read_check(a);
    endtask

    // Hold reset for some cycles, then count cycles until in_ready rises.
    task automatic do_reset(input int hold);
        int n;
        int dones;
        dones = 0;
        @(negedge pclk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (hold) begin
            @(negedge pclk);
            if (update_done) dones++;
        end
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_update_done", int'(update_done), 0);
        check_eq("rst_chan_err", int'(chan_err), 0);
        check_eq("rst_char_code", int'(char_code), 32'h20);
        rst = 1'b0;
        model_clear();
        last_done_cycle = -1;
        n = 0;
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge pclk);
            n++;
            if (update_done) dones++;
        end
        check_eq("ready_latency", n, 208);
        check_eq("no_done_in_reset", dones, 0);
        $display("reset: hold=%0d in_ready after %0d cycles", hold, n);
    endtask

    // Offer a measurement and leave once it has been accepted.
    task automatic start_tx(input int ch, input int mv);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check_eq("ready_before_offer", int'(in_ready), 1);
        in_channel = 4'(ch);
        in_mv = 12'(mv);
        in_valid = 1'b1;
        @(posedge pclk);
        #1;
        in_valid = 1'b0;
        in_channel = 4'($urandom_range(0, 15));
        in_mv = 12'($urandom_range(0, 4095));
        $display("tx: ch=%0d mv=%0d accepted at cycle %0d", ch, mv, cycle);
    endtask

    // Wait for update_done after an accept; optionally probe the read-during-
    // write behaviour on one column of the row being rewritten.
    task automatic wait_done(input int ch, input int mv, input int probe_col);
        int  n;
        int  low;
        bit  got;
        int  paddr;
        n = 0;
        low = 0;
        got = 0;
        paddr = ch*COLS + probe_col;
        while (n < 40 && !got) begin
            @(negedge pclk);
            n++;
            if (probe_col >= 0) begin
                if (n == 13 + probe_col) text_xy = 8'(paddr);
                if (n == 14 + probe_col)
                    check_eq("rdw_old", int'(char_code), int'(model[paddr]));
                if (n == 15 + probe_col)
                    check_eq("rdw_new", int'(char_code), int'(exp_char(ch, probe_col, mv)));
            end
            if (update_done) got = 1;
            else if (!in_ready) low++;
        end
        check_eq("done_latency", n, 26);
        check_eq("ready_low_cycles", low, 25);
        check_eq("ready_with_done", int'(in_ready), 1);
        model_set_row(ch, mv);
        if (last_done_cycle >= 0 && ch == 0 && probe_col == -2)
            check_eq("done_spacing", int'(cycle - last_done_cycle), 26);
        last_done_cycle = cycle;
    endtask

    task automatic bad_tx(input int ch, input int mv);
        int dones;
        int errs;
        start_tx(ch, mv);
        @(negedge pclk);
        check_eq("chan_err_pulse", int'(chan_err), 1);
        check_eq("bad_ready_high", int'(in_ready), 1);
        dones = 0;
        errs = 0;
        repeat (30) begin
            @(negedge pclk);
            if (update_done) dones++;
            if (chan_err) errs++;
        end
        check_eq("bad_no_done", dones, 0);
        check_eq("bad_err_once", errs, 0);
    endtask

    initial begin
        int ch;
        int mv;
        int dones;

        model_clear();
        do_reset(3);
        check_all();

        // Out-of-range addresses and the first cell.
        text_xy = 8'd200;
        @(negedge pclk);
        text_xy = 8'd230;
        check_eq("xy200", int'(char_code), 32'h20);
        @(negedge pclk);
        text_xy = 8'd0;
        check_eq("xy230", int'(char_code), 32'h20);
        @(negedge pclk);
        check_eq("xy0", int'(char_code), 32'h43);

        // Single update, with a read-during-write probe on the tens digit.
        start_tx(5, 3307);
        wait_done(5, 3307, 7);
        check_all();

        // Back-to-back: second offer lands in the update_done cycle.
        start_tx(12, 4095);
        wait_done(12, 4095, -1);
        start_tx(0, 7);
        wait_done(0, 7, -2);
        check_row(12);
        check_row(0);

        // Out-of-range channel: memory must be untouched.
        bad_tx(13, 100);
        check_all();

        // Randomised traffic, boundary values mixed in.
        for (int i = 0; i < 24; i++) begin
            ch = $urandom_range(0, 15);
            case (i % 6)
                0:       mv = 0;
                1:       mv = 4095;
                default: mv = $urandom_range(0, 4095);
            endcase
            if (ch >= CHANNELS) begin
                bad_tx(ch, mv);
            end else begin
                start_tx(ch, mv);
                wait_done(ch, mv, (i % 3 == 0) ? int'($urandom_range(0, 12)) : -1);
                check_row(ch);
            end
        end
        check_all();

        // Reset in the middle of a row rewrite.
        start_tx(3, 1234);
        dones = 0;
        repeat (22) begin
            @(negedge pclk);
            if (update_done) dones++;
        end
        check_eq("abort_no_done_before", dones, 0);
        do_reset(1);
        check_all();
        check_row(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
